lcd_fill_sequencer: RTL and testbench

Bus-master sequencer that drives the `spi_controller` register interface to paint a rectangular window of an ILI9341-class LCD with a single 16-bit colour. It sits between the SoC and `spi_controller`, taking a window and colour on simple control ports. It issues the column/row address commands, RAMWR, and every pixel byte, one SPI byte at a time. This offloads per-byte register pokes from the CPU.

---
 rtl/lcd_fill_sequencer_if.sv | 31 +++
 rtl/lcd_fill_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_lcd_fill_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_fill_sequencer_if.sv
// Register-bus connection between the fill sequencer (master) and the
// spi_controller register block (slave).
interface lcd_fill_sequencer_if;
  logic [31:0] spi_address_out;
  logic        spi_sel_out;
  logic        spi_read_out;
  logic [3:0]  spi_write_mask_out;
  logic [31:0] spi_write_value_out;
  logic [31:0] spi_read_value_in;
  logic        spi_ready_in;

  modport master (
    output spi_address_out,
    output spi_sel_out,
    output spi_read_out,
    output spi_write_mask_out,
    output spi_write_value_out,
    input  spi_read_value_in,
    input  spi_ready_in
  );

  modport slave (
    input  spi_address_out,
    input  spi_sel_out,
    input  spi_read_out,
    input  spi_write_mask_out,
    input  spi_write_value_out,
    output spi_read_value_in,
    output spi_ready_in
  );
endinterface

// File: rtl/lcd_fill_sequencer.sv
// Paints a rectangular LCD window with one RGB565 colour by pushing the
// CASET / PASET / RAMWR command stream and all pixel bytes through the
// spi_controller register interface, one byte per DC/DATA/CTRL/poll round.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; window and colour latched on accept
// S_LOAD    | pick next byte and its DC level (or abort on bad window)
// S_WR_DC   | write DC register
// S_WR_DATA | write DATA register with the byte
// S_WR_CTRL | write CTRL = 1 to launch the transfer
// S_POLL    | read STATUS until the byte completes or the poll times out
// S_DONE    | one-cycle done pulse, busy low
module lcd_fill_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_WIDTH       = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [8:0]           x0,
  input  logic [8:0]           x1,
  input  logic [8:0]           y0,
  input  logic [8:0]           y1,
  input  logic [15:0]          color,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  lcd_fill_sequencer_if.master spi
);

  localparam logic [31:0] ADDR_DATA   = 32'h0;
  localparam logic [31:0] ADDR_CTRL   = 32'h4;
  localparam logic [31:0] ADDR_STATUS = 32'h8;
  localparam logic [31:0] ADDR_DC     = 32'hC;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR_DC, S_WR_DATA, S_WR_CTRL, S_POLL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [8:0]           x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]          color_q, color_d;
  logic                 win_ok_q, win_ok_d;
  logic [18:0]          pix_cnt_q, pix_cnt_d;
  logic [3:0]           hdr_idx_q, hdr_idx_d;
  logic                 in_pix_q, in_pix_d;
  logic                 pix_lo_q, pix_lo_d;
  logic [7:0]           byte_q, byte_d;
  logic                 dc_q, dc_d;
  logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_d;
  logic                 seen_busy_q, seen_busy_d;
  logic                 error_q, error_d;

  logic [9:0]           win_w, win_h;
  logic [7:0]           sel_byte;
  logic                 sel_dc;
  logic                 byte_ok;
  logic [1:0]           status;
  logic                 unused_status_bits;

  logic [31:0]          addr_c, wval_c;
  logic                 sel_c, read_c;
  logic [3:0]           mask_c;

  assign status             = spi.spi_read_value_in[1:0];
  assign unused_status_bits = ^spi.spi_read_value_in[31:2];

  // Window size from the live inputs; only meaningful for a valid window.
  assign win_w = {1'b0, x1} - {1'b0, x0} + 10'd1;
  assign win_h = {1'b0, y1} - {1'b0, y0} + 10'd1;

  // Byte/DC selection: 11 header bytes, then colour high/low per pixel.
  always_comb begin
    sel_byte = 8'h00;
    sel_dc   = 1'b1;
    if (in_pix_q) begin
      sel_byte = pix_lo_q ? color_q[7:0] : color_q[15:8];
    end else begin
      case (hdr_idx_q)
        4'd0:    begin sel_byte = 8'h2A; sel_dc = 1'b0; end
        4'd1:    sel_byte = {7'd0, x0_q[8]};
        4'd2:    sel_byte = x0_q[7:0];
        4'd3:    sel_byte = {7'd0, x1_q[8]};
        4'd4:    sel_byte = x1_q[7:0];
        4'd5:    begin sel_byte = 8'h2B; sel_dc = 1'b0; end
        4'd6:    sel_byte = {7'd0, y0_q[8]};
        4'd7:    sel_byte = y0_q[7:0];
        4'd8:    sel_byte = {7'd0, y1_q[8]};
        4'd9:    sel_byte = y1_q[7:0];
        4'd10:   begin sel_byte = 8'h2C; sel_dc = 1'b0; end
        default: sel_byte = 8'h00;
      endcase
    end
  end

  // Next-state, datapath updates and bus drive.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    win_ok_d    = win_ok_q;
    pix_cnt_d   = pix_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    in_pix_d    = in_pix_q;
    pix_lo_d    = pix_lo_q;
    byte_d      = byte_q;
    dc_d        = dc_q;
    to_cnt_d    = to_cnt_q;
    seen_busy_d = seen_busy_q;
    error_d     = error_q;
    byte_ok     = 1'b0;
    addr_c      = 32'd0;
    wval_c      = 32'd0;
    sel_c       = 1'b0;
    read_c      = 1'b0;
    mask_c      = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d      = x0;
          x1_d      = x1;
          y0_d      = y0;
          y1_d      = y1;
          color_d   = color;
          win_ok_d  = (x1 >= x0) && (y1 >= y0);
          pix_cnt_d = 19'(win_w) * 19'(win_h);
          hdr_idx_d = 4'd0;
          in_pix_d  = 1'b0;
          pix_lo_d  = 1'b0;
          error_d   = 1'b0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!win_ok_q) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          byte_d  = sel_byte;
          dc_d    = sel_dc;
          state_d = S_WR_DC;
        end
      end

      S_WR_DC: begin
        sel_c  = 1'b1;
        addr_c = ADDR_DC;
        mask_c = 4'b0001;
        wval_c = {31'd0, dc_q};
        if (spi.spi_ready_in) state_d = S_WR_DATA;
      end

      S_WR_DATA: begin
        sel_c  = 1'b1;
        addr_c = ADDR_DATA;
        mask_c = 4'b0001;
        wval_c = {24'd0, byte_q};
        if (spi.spi_ready_in) state_d = S_WR_CTRL;
      end

      S_WR_CTRL: begin
        sel_c  = 1'b1;
        addr_c = ADDR_CTRL;
        mask_c = 4'b0001;
        wval_c = 32'd1;
        if (spi.spi_ready_in) begin
          to_cnt_d    = '0;
          seen_busy_d = 1'b0;
          state_d     = S_POLL;
        end
      end

      S_POLL: begin
        sel_c  = 1'b1;
        read_c = 1'b1;
        addr_c = ADDR_STATUS;
        if (spi.spi_ready_in) begin
          // A byte is finished on an explicit done flag, or on busy falling
          // after it was seen high (covers controllers that never flag done).
          if (status[1] || (!status[0] && seen_busy_q)) byte_ok = 1'b1;
          else if (status[0]) seen_busy_d = 1'b1;
        end
        if (byte_ok) begin
          state_d = S_LOAD;
          if (!in_pix_q) begin
            if (hdr_idx_q == 4'd10) begin
              in_pix_d = 1'b1;
              pix_lo_d = 1'b0;
            end else begin
              hdr_idx_d = hdr_idx_q + 4'd1;
            end
          end else if (!pix_lo_q) begin
            pix_lo_d = 1'b1;
          end else begin
            pix_lo_d  = 1'b0;
            pix_cnt_d = pix_cnt_q - 19'd1;
            if (pix_cnt_q == 19'd1) state_d = S_DONE;
          end
        end else if (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      win_ok_q    <= 1'b0;
      pix_cnt_q   <= '0;
      hdr_idx_q   <= '0;
      in_pix_q    <= 1'b0;
      pix_lo_q    <= 1'b0;
      byte_q      <= '0;
      dc_q        <= 1'b0;
      to_cnt_q    <= '0;
      seen_busy_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      win_ok_q    <= win_ok_d;
      pix_cnt_q   <= pix_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      in_pix_q    <= in_pix_d;
      pix_lo_q    <= pix_lo_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      to_cnt_q    <= to_cnt_d;
      seen_busy_q <= seen_busy_d;
      error_q     <= error_d;
    end
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done  = (state_q == S_DONE);
  assign error = error_q;

  assign spi.spi_address_out     = addr_c;
  assign spi.spi_sel_out         = sel_c;
  assign spi.spi_read_out        = read_c;
  assign spi.spi_write_mask_out  = mask_c;
  assign spi.spi_write_value_out = wval_c;

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Bench for lcd_fill_sequencer: behavioural spi_controller model, byte/DC
// scoreboard, and directed fills (single pixel, multi-pixel, bad window,
// bus stall, poll timeout, mid-fill reset).
module tb_lcd_fill_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  x0, x1, y0, y1;
  logic [15:0] color;
  logic        busy, done, error;
  logic        rdy;
  int          mode;   // 0: busy for two reads then idle, 1: done flag at once, 2: stuck busy

  lcd_fill_sequencer_if bus();

  lcd_fill_sequencer #(.TIMEOUT_CYCLES(64), .TO_WIDTH(13)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy), .done(done), .error(error), .spi(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // spi_controller model
  logic [1:0] m_cnt = 2'd0;
  logic [1:0] m_stat;
  always_comb begin
    m_stat = 2'b00;
    if (mode == 2)          m_stat = 2'b01;
    else if (m_cnt != 2'd0) m_stat = 2'b01;
    else if (mode == 1)     m_stat = 2'b10;
  end
  assign bus.spi_read_value_in = {30'd0, m_stat};
  assign bus.spi_ready_in      = rdy;

  always @(posedge clk) begin
    if (bus.spi_sel_out && rdy) begin
      if (!bus.spi_read_out && bus.spi_address_out == 32'h4)
        m_cnt <= (mode == 0) ? 2'd2 : 2'd0;
      else if (bus.spi_read_out && m_cnt != 2'd0)
        m_cnt <= m_cnt - 2'd1;
    end
  end

  // Scoreboard of {dc, byte} expected on DATA writes
  logic [8:0] exp_q[$];
  logic       cur_dc = 1'b0;
  int cyc = 0, sel_cnt = 0, data_cnt = 0, ctrl_cnt = 0, done_cnt = 0;
  int last_ctrl_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (reset_n && bus.spi_sel_out) begin
      sel_cnt++;
      if (rdy && !bus.spi_read_out) begin
        check_val("wr_mask", {28'd0, bus.spi_write_mask_out}, 32'h1);
        if (bus.spi_address_out == 32'hC) begin
          cur_dc = bus.spi_write_value_out[0];
        end else if (bus.spi_address_out == 32'h0) begin
          data_cnt++;
          if (exp_q.size() == 0) begin
            check_val("extra_byte", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_val("dc_byte", {23'd0, cur_dc, bus.spi_write_value_out[7:0]}, {23'd0, e});
            check_val("data_upper", {8'd0, bus.spi_write_value_out[31:8]}, 32'd0);
          end
        end else if (bus.spi_address_out == 32'h4) begin
          ctrl_cnt++;
          last_ctrl_cyc = cyc;
          check_val("ctrl_val", bus.spi_write_value_out, 32'h1);
        end
      end
    end
  end

  task automatic push_window(input logic [8:0] a0, a1, b0, b1, input logic [15:0] c);
    int n;
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 7'd0, a0[8]}); exp_q.push_back({1'b1, a0[7:0]});
    exp_q.push_back({1'b1, 7'd0, a1[8]}); exp_q.push_back({1'b1, a1[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 7'd0, b0[8]}); exp_q.push_back({1'b1, b0[7:0]});
    exp_q.push_back({1'b1, 7'd0, b1[8]}); exp_q.push_back({1'b1, b1[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    n = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  // Start is sampled by the posedge that ends this task's first cycle.
  task automatic do_start(input logic [8:0] a0, a1, b0, b1, input logic [15:0] c);
    @(posedge clk); #1;
    start = 1'b1; x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_val({tag, "_done"},  {31'd0, done}, 32'd0);
    check_val({tag, "_error"}, {31'd0, error}, 32'd0);
    check_val({tag, "_sel"},   {31'd0, bus.spi_sel_out}, 32'd0);
    check_val({tag, "_read"},  {31'd0, bus.spi_read_out}, 32'd0);
    check_val({tag, "_mask"},  {28'd0, bus.spi_write_mask_out}, 32'd0);
    check_val({tag, "_addr"},  bus.spi_address_out, 32'd0);
    check_val({tag, "_wval"},  bus.spi_write_value_out, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    logic found;
    reset_n = 1'b0; start = 1'b0; rdy = 1'b1; mode = 0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    #3 check_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single pixel 5,7 red
    done_cnt = 0; data_cnt = 0;
    push_window(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    do_start(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    @(negedge clk);
    check_val("t1_busy_rise", {31'd0, busy}, 32'd1);
    wait_done("t1_done", 3000);
    check_val("t1_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_bytes", data_cnt, 13);
    check_val("t1_sb_empty", exp_q.size(), 0);
    check_val("t1_busy_low", {31'd0, busy}, 32'd0);

    // 10x5 window, done-flag completion: 11 + 2*50 CTRL writes
    mode = 1; ctrl_cnt = 0;
    push_window(9'd0, 9'd9, 9'd0, 9'd4, 16'h1234);
    do_start(9'd0, 9'd9, 9'd0, 9'd4, 16'h1234);
    wait_done("t2_done", 5000);
    check_val("t2_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_val("t2_ctrl_cnt", ctrl_cnt, 111);
    check_val("t2_sb_empty", exp_q.size(), 0);

    // invalid window x0=10, x1=9
    mode = 0; sel_cnt = 0;
    do_start(9'd10, 9'd9, 9'd0, 9'd0, 16'hFFFF);
    @(negedge clk);
    check_val("inv_busy", {31'd0, busy}, 32'd1);
    check_val("inv_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check_val("inv_done", {31'd0, done}, 32'd1);
    check_val("inv_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check_val("inv_done_pulse", {31'd0, done}, 32'd0);
    check_val("inv_error_sticky", {31'd0, error}, 32'd1);
    check_val("inv_sel_cycles", sel_cnt, 0);
    push_window(9'd1, 9'd1, 9'd1, 9'd1, 16'h0F0F);
    do_start(9'd1, 9'd1, 9'd1, 9'd1, 16'h0F0F);
    @(negedge clk);
    check_val("err_cleared", {31'd0, error}, 32'd0);
    wait_done("t3_done", 3000);
    @(negedge clk);
    check_val("t3_sb_empty", exp_q.size(), 0);

    // stall on first DATA write, plus a start that must be ignored
    ctrl_cnt = 0;
    push_window(9'd3, 9'd4, 9'd0, 9'd0, 16'hA5C3);
    do_start(9'd3, 9'd4, 9'd0, 9'd0, 16'hA5C3);
    k = 0; found = 1'b0;
    while (!found && k < 200) begin
      @(posedge clk); #1;
      if (bus.spi_sel_out && !bus.spi_read_out && bus.spi_address_out == 32'h0) found = 1'b1;
      k++;
    end
    check_val("stall_found", {31'd0, found}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_addr", bus.spi_address_out, 32'h0);
      check_val("stall_wval", bus.spi_write_value_out, 32'h2A);
      check_val("stall_sel", {31'd0, bus.spi_sel_out}, 32'd1);
      if (i == 1) begin
        start = 1'b1; x0 = 9'd0; x1 = 9'd100; y0 = 9'd0; y1 = 9'd100; color = 16'h1111;
      end
      if (i == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done("t4_done", 3000);
    check_val("t4_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_val("t4_ctrl_cnt", ctrl_cnt, 15);
    check_val("t4_sb_empty", exp_q.size(), 0);

    // stuck STATUS: 64 polling cycles after WR_CTRL, DONE in the next cycle
    mode = 2; data_cnt = 0;
    exp_q.push_back({1'b0, 8'h2A});
    do_start(9'd0, 9'd0, 9'd0, 9'd0, 16'hFFFF);
    wait_done("t5_done", 500);
    check_val("to_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check_val("to_latency", last_done_cyc - last_ctrl_cyc, 65);
    repeat (10) @(negedge clk);
    check_val("to_data_writes", data_cnt, 1);
    check_val("to_sb_empty", exp_q.size(), 0);

    // reset in the middle of the pixel stream
    mode = 0; data_cnt = 0;
    push_window(9'd0, 9'd3, 9'd0, 9'd3, 16'h5A5A);
    do_start(9'd0, 9'd3, 9'd0, 9'd3, 16'h5A5A);
    k = 0;
    while (data_cnt < 15 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val("rst_in_pixels", {31'd0, data_cnt >= 15}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_zero("mid_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    sel_cnt = 0;
    repeat (20) @(negedge clk);
    check_val("rst_no_sel", sel_cnt, 0);
    check_val("rst_idle_busy", {31'd0, busy}, 32'd0);

    // recovery fill after reset
    mode = 1;
    push_window(9'd2, 9'd2, 9'd3, 9'd3, 16'h07E0);
    do_start(9'd2, 9'd2, 9'd3, 9'd3, 16'h07E0);
    wait_done("t7_done", 3000);
    check_val("t7_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_val("t7_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
